// File: rtl/tick_recv_pkg.sv
// rtl/tick_recv_pkg.sv - shared types and defaults for the tick receiver
package tick_recv_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_e;

    localparam logic RST_ACTIVE          = 1'b0;
    localparam int   DEF_SYNC_STAGES     = 2;
    localparam int   DEF_DEBOUNCE_CYCLES = 16;
    localparam int   DEF_CNT_W           = 31;

endpackage

// File: rtl/tick_recv_if.sv
// rtl/tick_recv_if.sv - slow input and step/period outputs of the tick receiver
interface tick_recv_if #(
    parameter int CNT_W = tick_recv_pkg::DEF_CNT_W
) ();

    logic             slow_in;
    logic             level;
    logic             step_en;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             overflow;

    modport master (
        output slow_in,
        input  level,
        input  step_en,
        input  period,
        input  period_valid,
        input  overflow
    );

    modport slave (
        input  slow_in,
        output level,
        output step_en,
        output period,
        output period_valid,
        output overflow
    );

endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage level synchronizer, async active-low reset to 0
module sync_ff
    import tick_recv_pkg::*;
#(
    parameter int N = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/tick_recv.sv
// rtl/tick_recv.sv - sync/debounce a slow level into a one-cycle step enable and measure its period
// Define TICK_RECV_FALL_EN to also pulse step_en on accepted falling edges.
module tick_recv
    import tick_recv_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic        clk,
    input logic        rst,
    tick_recv_if.slave bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Compared against the count before increment so acceptance lands on the final stable cycle.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);

    logic s;

    state_e           state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             step_en_q, step_d;
    logic             rise_evt;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             overflow_q, overflow_d;
    logic             armed_q, armed_d;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.slow_in),
        .q_o (s)
    );

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        rise_evt = 1'b0;
        step_d   = 1'b0;
        unique case (state_q)
            LOW: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d  = HIGH;
                        level_d  = 1'b1;
                        rise_evt = 1'b1;
                    end else begin
                        state_d  = RISE_CHK;
                        db_cnt_d = '0;
                    end
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_d = LOW;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = HIGH;
                    level_d  = 1'b1;
                    rise_evt = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = LOW;
                        level_d = 1'b0;
`ifdef TICK_RECV_FALL_EN
                        step_d  = 1'b1;
`endif
                    end else begin
                        state_d  = FALL_CHK;
                        db_cnt_d = '0;
                    end
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_d = HIGH;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = LOW;
                    level_d = 1'b0;
`ifdef TICK_RECV_FALL_EN
                    step_d  = 1'b1;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOW;
            end
        endcase
        if (rise_evt) begin
            step_d = 1'b1;
        end
    end

    assign per_inc = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CNT_W'(1);

    always_comb begin
        per_cnt_d      = per_inc;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        overflow_d     = overflow_q;
        armed_d        = armed_q;
        // The first rise after reset has no reference edge, so it only arms.
        if (rise_evt) begin
            per_cnt_d  = '0;
            period_d   = per_inc;
            overflow_d = (per_cnt_q == '1);
            armed_d    = 1'b1;
            if (armed_q) begin
                period_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q        <= LOW;
            db_cnt_q       <= '0;
            level_q        <= 1'b0;
            step_en_q      <= 1'b0;
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            db_cnt_q       <= db_cnt_d;
            level_q        <= level_d;
            step_en_q      <= step_d;
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            overflow_q     <= overflow_d;
            armed_q        <= armed_d;
        end
    end

    assign bus.level        = level_q;
    assign bus.step_en      = step_en_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: doc/tick_recv.md
Name: tick_recv

Overview:
- Receive end of the board-level divided clock (fp_clk) or a manual step input.
- Takes a slow, asynchronous, possibly bouncy level into the fast clk domain.
- Synchronizes and debounces it, then emits a single-cycle step enable so CPU logic stays on one clock.
- Also measures the slow signal's period in clk cycles, so the team can check the divider on the FPGA board.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable clk cycles needed to accept a level change; must be ≥1.
- CNT_W, 31: width of the period counter and the period output.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- slow_in  in  1  asynchronous slow level (divided clock or step button)
- level  out  1  debounced, synchronized copy of slow_in
- step_en  out  1  one-cycle pulse per accepted rising edge
- period  out  CNT_W  clk cycles between the last two accepted rising edges
- period_valid  out  1  period holds a real measurement
- overflow  out  1  last interval saturated the counter

Behaviour:
- Reset is asynchronous, active low. While rst=0:
  - Synchronizer flops and level = 0.
  - step_en = 0, period = 0, period_valid = 0, overflow = 0.
  - Internal counters = 0; FSM = LOW.
- Synchronizer: SYNC_STAGES flops in series. s = last flop output. No other logic reads slow_in.
- FSM states and transitions:
  - LOW: if s=1, go to RISE_CHK and set db_cnt=0.
  - RISE_CHK:
    - if s=0, go back to LOW (glitch rejected);
    - else db_cnt++;
    - when db_cnt==DEBOUNCE_CYCLES-1 and s=1, go to HIGH, set level<=1, and raise rise_evt.
  - HIGH: if s=0, go to FALL_CHK and set db_cnt=0.
  - FALL_CHK:
    - if s=1, go back to HIGH;
    - else db_cnt++;
    - when db_cnt==DEBOUNCE_CYCLES-1, go to LOW and set level<=0.
- Latency for a clean rising edge on slow_in: step_en is high on exactly the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising clk edge after the first edge that samples slow_in=1.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4 gives 6 edges.
  - step_en stays high for exactly one cycle.
  - Falling-edge latency is the same; it moves level only.
- Pulses shorter than DEBOUNCE_CYCLES after synchronization produce no change on level or step_en.
- Period counter per_cnt:
  - Every cycle: per_cnt <= per_cnt+1, saturating at all-ones.
  - On a rise_evt cycle:
    - period <= sat(per_cnt+1) and overflow <= (per_cnt == all-ones).
    - per_cnt <= 0.
    - period_valid <= 1, but only from the second rise_evt after reset; the first rise only arms the measurement.
  - Result: evenly spaced rises P cycles apart report period=P.
  - period and overflow hold their value between rise events.
- Reset mid-debounce: counters are cleared immediately and no step_en is issued. After reset release, a slow_in that is still high is treated as a new rise and must complete the full debounce.
- No combinational path from slow_in to any output.

Optional Feature:
- Macro: TICK_RECV_FALL_EN.
- Defined: step_en also pulses once on each accepted falling edge, on the cycle FALL_CHK goes to LOW. This doubles the step rate when slow_in is a 50% duty divided clock. The period measurement still uses rising edges only.
- Undefined: step_en pulses on rising edges only, and the falling path drives level only.

Decomposition:
- Package tick_recv_pkg holds:
  - the state enum: LOW, RISE_CHK, HIGH, FALL_CHK;
  - the reset-active constant for active-low reset;
  - the default SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module: sync_ff.
  - Parameterized N-stage synchronizer, asynchronous active-low reset to 0.
  - Kept separate so CDC lint waivers attach to a single instance.
- The FSM, debounce counter and period counter live in tick_recv.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=8 unless noted):
- Clean rise held high: step_en high exactly 6 edges after the first sampled 1, for 1 cycle; level goes to 1 on the same edge.
- 3-cycle high glitch on slow_in: step_en stays 0 throughout; level stays 0.
- Square wave with 100-cycle period, 50% duty:
  - step_en every 100 cycles;
  - period_valid=0 after the first rise;
  - period=100 and period_valid=1 after the second rise;
  - overflow=0.
- Rises 300 cycles apart with CNT_W=8: period=255, overflow=1. A following 100-cycle interval gives period=100, overflow=0.
- rst=0 asserted 2 cycles into RISE_CHK, released with slow_in still high:
  - all outputs 0 during reset;
  - step_en exactly 6 edges after release.
- With TICK_RECV_FALL_EN, 100-cycle square wave: step_en pulses every 50 cycles, and period still reads 100.
